// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state, J opcode and instruction field slices.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_J = 6'b000010;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

    function automatic logic [31:0] j_target(input logic [31:0] pc_plus4, input logic [31:0] instr);
        return {pc_plus4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parameterized DEPTH-entry FIFO with synchronous flush; used for the pc queue and the fetch buffer.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push = push_i && ((count_q != CW'(DEPTH)) || pop_i);
        do_pop  = pop_i && (count_q != '0);
        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the consumer only looks at it when count_o is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// MIPS IF stage: PC, in-order imem requests, fetch buffer, redirect flush.
// Optional J predecode redirect: define FETCH_JUMP_PREDECODE_EN.
import fetch_pkg::*;

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d;
    logic [CW-1:0] pcq_cnt, buf_cnt;
    logic [31:0]   pcq_head;
    logic [63:0]   buf_head;
    logic [CW:0]   slots;
    logic          issue, rsp, rsp_keep, ext_redir, int_redir, redir, id_fire;
    logic [31:0]   jtarget;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RST;
        else       state_q <= state_d;
    end

    always_comb begin
        case (state_q)
            ST_RST:  state_d = ST_FETCH;
            default: state_d = (drop_d != '0) ? ST_FLUSH : ST_FETCH;
        endcase
    end

    // A slot is owed to every in-flight request plus every buffered entry not leaving this cycle.
    always_comb begin
        id_valid       = (buf_cnt != '0);
        id_fire        = id_valid && id_ready;
        slots          = {1'b0, inflight_q} + {1'b0, buf_cnt} - (CW+1)'(id_fire);
        imem_req_valid = (state_q == ST_FETCH) && (slots < (CW+1)'(DEPTH));
        imem_req_addr  = pc_q;
        id_instr       = id_valid ? buf_head[63:32] : 32'h0;
        id_pc          = id_valid ? buf_head[31:0]  : 32'h0;
    end

    always_comb begin
        issue     = imem_req_valid && imem_req_ready;
        rsp       = imem_rsp_valid && (state_q != ST_RST);
        ext_redir = redirect_valid && (state_q != ST_RST);
        rsp_keep  = rsp && (drop_q == '0) && !ext_redir && (pcq_cnt != '0);
`ifdef FETCH_JUMP_PREDECODE_EN
        jtarget   = j_target(pcq_head + 32'd4, imem_rsp_data);
        int_redir = rsp_keep && (imem_rsp_data[OP_MSB:OP_LSB] == OP_J);
`else
        jtarget   = 32'h0;
        int_redir = 1'b0;
`endif
        redir      = ext_redir || int_redir;
        inflight_d = inflight_q + CW'(issue) - CW'(rsp);
        // After a redirect every outstanding response (incl. one issued now) is stale.
        drop_d     = redir ? inflight_d : drop_q - CW'(rsp && (drop_q != '0));
        if (ext_redir)      pc_d = redirect_pc & ~32'h3;
        else if (int_redir) pc_d = jtarget;
        else if (issue)     pc_d = pc_q + 32'd4;
        else                pc_d = pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC & ~32'h3;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_pcq (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redir),
        .push_i  (issue),
        .wdata_i (pc_q),
        .pop_i   (rsp_keep),
        .rdata_o (pcq_head),
        .count_o (pcq_cnt)
    );

    // Only an external redirect clears the buffer; a predecoded J keeps older entries and itself.
    fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .flush_i (ext_redir),
        .push_i  (rsp_keep),
        .wdata_i ({imem_rsp_data, pcq_head}),
        .pop_i   (id_fire),
        .rdata_o (buf_head),
        .count_o (buf_cnt)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order latency-k instruction memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 1;
    bit jmode = 1'b0;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] req_addr[$], req_cyc[$];
    logic [31:0] dlv_pc[$], dlv_instr[$], dlv_cyc[$];

    instr_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jmode && a == 32'h0000_0010) return 32'h0800_0040;
        return a ^ 32'h5500_0000;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory drives at negedge, handshakes sampled just after, returns at posedge+1.
    task automatic tick();
        @(negedge clk);
        imem_rsp_valid = (mq_addr.size() != 0) && (mq_due[0] <= cyc);
        imem_rsp_data  = imem_rsp_valid ? mem_word(mq_addr[0]) : 32'h0;
        #1;
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + lat);
                req_addr.push_back(imem_req_addr);
                req_cyc.push_back(32'(cyc));
            end
            if (imem_rsp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (id_valid && id_ready) begin
                dlv_pc.push_back(id_pc);
                dlv_instr.push_back(id_instr);
                dlv_cyc.push_back(32'(cyc));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        mq_addr.delete(); mq_due.delete();
        req_addr.delete(); req_cyc.delete();
        dlv_pc.delete(); dlv_instr.delete(); dlv_cyc.delete();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int old_cnt;

        // Streaming, k=1, decode always ready
        lat = 1; jmode = 1'b0;
        do_reset();
        id_ready = 1'b1;
        ticks(8);
        chk("t1_req0", qget(req_addr, 0), 32'h0);
        chk("t1_req1", qget(req_addr, 1), 32'h4);
        chk("t1_req2", qget(req_addr, 2), 32'h8);
        chk("t1_req0_cyc", qget(req_cyc, 0), 32'd1);
        chk("t1_pc0", qget(dlv_pc, 0), 32'h0);
        chk("t1_pc1", qget(dlv_pc, 1), 32'h4);
        chk("t1_pc2", qget(dlv_pc, 2), 32'h8);
        chk("t1_cyc0", qget(dlv_cyc, 0), 32'd3);
        chk("t1_cyc1", qget(dlv_cyc, 1), 32'd4);
        chk("t1_cyc2", qget(dlv_cyc, 2), 32'd5);
        chk("t1_instr0", qget(dlv_instr, 0), 32'h5500_0000);

        // Decode stalled: bounded issue, held output, nothing lost (reset lands mid-stream)
        do_reset();
        ticks(4);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", {31'h0, id_valid}, 32'h1);
            chk("t2_hold_instr", id_instr, 32'h5500_0000);
            chk("t2_hold_pc", id_pc, 32'h0);
            tick();
        end
        chk("t2_req_cnt", 32'(req_addr.size()), 32'd2);
        id_ready = 1'b1;
        ticks(12);
        for (int i = 0; i < 6; i++) begin
            chk("t2_pc", qget(dlv_pc, i), 32'(4 * i));
            chk("t2_instr", qget(dlv_instr, i), 32'(4 * i) ^ 32'h5500_0000);
        end

        // Redirect with two requests in flight (k=3)
        lat = 3;
        do_reset();
        id_ready = 1'b1;
        ticks(3);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        ticks(12);
        chk("t3_req_new", qget(req_addr, 2), 32'h100);
        chk("t3_req_new_cyc", qget(req_cyc, 2), 32'd6);
        chk("t3_pc0", qget(dlv_pc, 0), 32'h100);
        chk("t3_pc1", qget(dlv_pc, 1), 32'h104);
        old_cnt = 0;
        foreach (dlv_pc[i]) if (dlv_pc[i] < 32'h100) old_cnt++;
        chk("t3_old_stream", 32'(old_cnt), 32'd0);

        // Redirect coinciding with a response and a decode handshake
        lat = 1;
        do_reset();
        id_ready = 1'b1;
        ticks(3);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        ticks(8);
        chk("t4_pc0", qget(dlv_pc, 0), 32'h0);
        chk("t4_pc1", qget(dlv_pc, 1), 32'h200);
        chk("t4_req3", qget(req_addr, 3), 32'h200);
        chk("t4_req3_cyc", qget(req_cyc, 3), 32'd5);

        // PC wrap at the top of the address space
        do_reset();
        id_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        ticks(10);
        chk("t5_req1", qget(req_addr, 1), 32'hFFFF_FFF8);
        chk("t5_req2", qget(req_addr, 2), 32'hFFFF_FFFC);
        chk("t5_req3", qget(req_addr, 3), 32'h0);
        chk("t5_pc0", qget(dlv_pc, 0), 32'hFFFF_FFF8);
        chk("t5_pc1", qget(dlv_pc, 1), 32'hFFFF_FFFC);
        chk("t5_pc2", qget(dlv_pc, 2), 32'h0);

        // J word at 0x10
        jmode = 1'b1;
        do_reset();
        id_ready = 1'b1;
        ticks(14);
        chk("t6_j_pc", qget(dlv_pc, 4), 32'h10);
        chk("t6_j_instr", qget(dlv_instr, 4), 32'h0800_0040);
`ifdef FETCH_JUMP_PREDECODE_EN
        chk("t6_after_j", qget(dlv_pc, 5), 32'h100);
        chk("t6_after_j2", qget(dlv_pc, 6), 32'h104);
`else
        chk("t6_after_j", qget(dlv_pc, 5), 32'h14);
        chk("t6_after_j2", qget(dlv_pc, 6), 32'h18);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
